// File: rtl/seq_row_merge_adder_pkg.sv
// Shared types and default geometry for the sequential row-merge adder.
// Derived slice counts follow the default width, slice and error position.
package seq_row_merge_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    localparam int WIDTH_DEF   = 32;
    localparam int SLICE_DEF   = 8;
    localparam int ERR_POS_DEF = 17;

    localparam int NUM_SLICES = WIDTH_DEF / SLICE_DEF;
    localparam int ERR_SLICE  = ERR_POS_DEF / SLICE_DEF;

endpackage

// File: rtl/seq_row_merge_adder_cpa_slice.sv
// One SLICE-wide carry-propagate step with a 2-bit carry and an optional
// single-bit injection at a fixed offset inside the slice.
module seq_row_merge_adder_cpa_slice #(
    parameter int SLICE   = 8,
    parameter int INJ_OFF = 1
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       cin,
    input  logic             inj,
    input  logic             inj_en,
    output logic [SLICE-1:0] sum,
    output logic [1:0]       cout
);

    logic [SLICE+1:0] full;
    logic [SLICE+1:0] inj_w;

    // Two extra bits hold the worst case: 2*(2^S-1) + 3 + 2^(S-1)
    always_comb begin
        inj_w          = '0;
        inj_w[INJ_OFF] = inj & inj_en;
        full = {2'b00, a} + {2'b00, b} + {{SLICE{1'b0}}, cin} + inj_w;
    end

    assign sum  = full[SLICE-1:0];
    assign cout = full[SLICE+1:SLICE];

endmodule

// File: rtl/seq_row_merge_adder.sv
// Final carry-propagate adder of the approximate multiplier: merges the two
// residual rows plus the dropped-carry flag, SLICE bits per cycle.
module seq_row_merge_adder
    import seq_row_merge_adder_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SLICE   = SLICE_DEF,
    parameter int ERR_POS = ERR_POS_DEF,
    parameter bit ERR_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_a,
    input  logic [WIDTH-1:0] row_b,
    input  logic             err_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             err_out,
    output logic             ovf
);

    localparam int NS   = WIDTH / SLICE;
    localparam int ES   = ERR_POS / SLICE;
    localparam int EOFF = ERR_POS % SLICE;
    localparam int CW   = (NS > 1) ? $clog2(NS) : 1;
    localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [IW-1:0]    base;
    logic [SLICE-1:0] s_sum;
    logic [1:0]       s_cout;
    logic             inj_en;
    logic             last;
    logic             load;

    assign base   = IW'(cnt_q) * IW'(SLICE);
    assign inj_en = ERR_EN && (cnt_q == CW'(ES));
    assign last   = (cnt_q == CW'(NS - 1));

    seq_row_merge_adder_cpa_slice #(
        .SLICE   (SLICE),
        .INJ_OFF (EOFF)
    ) u_slice (
        .a      (a_q[base +: SLICE]),
        .b      (b_q[base +: SLICE]),
        .cin    (carry_q),
        .inj    (err_q),
        .inj_en (inj_en),
        .sum    (s_sum),
        .cout   (s_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            ADD: begin
                prod_d[base +: SLICE] = s_sum;
                carry_d = s_cout;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    ovf_d   = |s_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Freeing the result slot lets a new operand pair in on the same edge
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                    load    = in_valid;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            a_d     = row_a;
            b_d     = row_b;
            err_d   = err_in;
            carry_d = '0;
            cnt_d   = '0;
            state_d = ADD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            carry_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign product   = prod_q;
    assign err_out   = err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_row_merge_adder.sv
// Scoreboard bench: two instances (error injection on and off) share stimulus;
// expected results come from plain wide arithmetic on the operands.
module tb_seq_row_merge_adder;

    localparam int W   = 32;
    localparam int EP  = 17;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         err_in = 1'b0;
    logic [W-1:0] row_a = '0;
    logic [W-1:0] row_b = '0;

    logic         in_ready1, out_valid1, err_out1, ovf1;
    logic         in_ready0, out_valid0, err_out0, ovf0;
    logic [W-1:0] product1, product0;

    always #5 clk = ~clk;

    seq_row_merge_adder #(.ERR_EN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready1),
        .row_a(row_a), .row_b(row_b), .err_in(err_in),
        .out_valid(out_valid1), .out_ready(out_ready),
        .product(product1), .err_out(err_out1), .ovf(ovf1)
    );

    seq_row_merge_adder #(.ERR_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0),
        .row_a(row_a), .row_b(row_b), .err_in(err_in),
        .out_valid(out_valid0), .out_ready(out_ready),
        .product(product0), .err_out(err_out0), .ovf(ovf0)
    );

    typedef struct {
        logic [W-1:0] p1;
        logic [W-1:0] p0;
        logic         e;
        logic         o1;
        logic         o0;
        int           acc;
        bit           seen;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rnd_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic e, input int acc);
        exp_t r;
        logic [W+1:0] s1, s0;
        s0 = {2'b00, a} + {2'b00, b};
        s1 = s0 + (e ? (34'd1 << EP) : 34'd0);
        r.p1   = s1[W-1:0];
        r.o1   = (s1[W+1:W] != 2'b00);
        r.p0   = s0[W-1:0];
        r.o0   = (s0[W+1:W] != 2'b00);
        r.e    = e;
        r.acc  = acc;
        r.seen = 1'b0;
        return r;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic e, input bit set_rdy);
        int n = 0;
        @(negedge clk);
        if (set_rdy) out_ready = 1'b1;
        in_valid = 1'b1;
        row_a = a;
        row_b = b;
        err_in = e;
        #1;
        while (!in_ready1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1");
            in_valid = 1'b0;
            return;
        end
        sbq.push_back(model(a, b, e, cyc));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
            sbq.delete();
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rnd_rdy) out_ready = (($urandom % 4) != 0);
    end

    // Monitor: compare the head of the scoreboard whenever a result is presented
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid1) begin
            if (sbq.size() == 0) begin
                chk("spurious_valid", 64'(out_valid1), 64'd0);
            end else begin
                if (!sbq[0].seen) begin
                    sbq[0].seen = 1'b1;
                    chk("latency", 64'(cyc - sbq[0].acc), 64'(LAT + 1));
                end
                chk("product_en", 64'(product1), 64'(sbq[0].p1));
                chk("ovf_en", 64'(ovf1), 64'(sbq[0].o1));
                chk("err_out_en", 64'(err_out1), 64'(sbq[0].e));
                chk("valid_dis", 64'(out_valid0), 64'd1);
                chk("product_dis", 64'(product0), 64'(sbq[0].p0));
                chk("ovf_dis", 64'(ovf0), 64'(sbq[0].o0));
                chk("err_out_dis", 64'(err_out0), 64'(sbq[0].e));
                if (!out_ready) chk("stall_in_ready", 64'(in_ready1), 64'd0);
                else void'(sbq.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        int n;
        #12;
        chk("rst_out_valid", 64'(out_valid1), 64'd0);
        chk("rst_product", 64'(product1), 64'd0);
        chk("rst_err_out", 64'(err_out1), 64'd0);
        chk("rst_ovf", 64'(ovf1), 64'd0);
        chk("rst_in_ready", 64'(in_ready1), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'h00000000, 32'h00000000, 1'b1, 1'b0);
        send(32'h0001FFFF, 32'h00000001, 1'b1, 1'b0);
        send(32'h00FFFFFF, 32'h00FFFFFF, 1'b1, 1'b0);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
        send(32'hFFFDFFFF, 32'h00000000, 1'b1, 1'b0);
        drain();

        out_ready = 1'b0;
        send(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0);
        n = 0;
        while (!out_valid1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached_valid", 64'(out_valid1), 64'd1);
        repeat (3) @(negedge clk);
        send(32'hCAFEF00D, 32'h01020304, 1'b0, 1'b1);
        drain();

        send(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sbq.pop_back());
        #1;
        chk("midrst_out_valid", 64'(out_valid1), 64'd0);
        chk("midrst_product", 64'(product1), 64'd0);
        chk("midrst_in_ready", 64'(in_ready1), 64'd1);
        chk("midrst_ovf", 64'(ovf1), 64'd0);
        chk("midrst_err_out", 64'(err_out1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom % 4)
                0: begin ra = 32'hFFFFFFFF; rb = $urandom; end
                1: begin ra = $urandom & 32'h0003FFFF; rb = $urandom & 32'h0003FFFF; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            repeat ($urandom % 3) @(negedge clk);
            send(ra, rb, 1'($urandom % 2), 1'b0);
        end
        drain();
        rnd_rdy = 1'b0;
        out_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
